mem_access_unit: RTL
====================

# mem_access_unit

Load/store access stage for the 64-bit datapath, sitting directly upstream of the data memory. Accepts one load or store request at a time via a valid/ready handshake and checks alignment and bounds. Converts byte addresses to word indices and performs byte/half/word/doubleword accesses; sub-doubleword stores use read-modify-write. Returns extended load data or an error flag to the datapath on a held response handshake.

## Interface
Parameters:
- DEPTH, 5: number of 64-bit memory words; valid word indices 0..DEPTH-1.

Ports (clock and reset first):
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word (32b), 11 doubleword.
- reqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- reqAddr  in  64  byte address.
- reqData  in  64  store data, right-justified (low bits used for sub-dword).
- rspValid  out  1  response available.
- rspReady  in  1  datapath takes response.
- rspData  out  64  extended load data; 0 for stores and errors.
- rspError  out  1  misaligned or out-of-range request.
- memRead  out  1  memory read enable.
- memWrite  out  1  memory write enable.
- memAddress  out  64  word index (reqAddr >> 3).
- memWriteData  out  64  full 64-bit word to write.
- memReadData  in  64  memory read data, combinational from memAddress while memRead=1.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: reqReady=1. When reqValid=1, latch all req fields, then evaluate:
  - Misaligned: byte never; half addr[0]!=0; word addr[1:0]!=0; dword addr[2:0]!=0.
  - Out of range: (addr>>3) >= DEPTH.
  - On either error, go to RESP with rspError=1 and rspData=0. No memory access occurs.
  - Load → READ. Dword store → WRITE. Sub-dword store → READ.
- READ: memRead=1, memAddress=word index; memReadData captured at the edge ending the cycle.
  - Load: select lane, extend per reqSigned/reqSize, then → RESP.
  - Store: merge reqData low bits into the selected lane, keep other bytes, then → WRITE.
- WRITE: memWrite=1, memAddress=word index, memWriteData=merged word (or reqData for dword) → RESP.
- RESP: rspValid=1 and reqReady=0; rspData/rspError held stable. On rspValid&rspReady → IDLE.
- Lanes are little-endian:
  - Byte k = bits [8k+7:8k], with k=addr[2:0].
  - Half at addr[2:1]*16.
  - Word at addr[2]*32.
- Sign-extend replicates the lane MSB; zero-extend fills with 0.
- Outside READ: memRead=0. Outside WRITE: memWrite=0, memWriteData=0. In IDLE and RESP: memAddress=0.

## Timing
- Cycle 0 is the accept cycle (reqValid&reqReady at rising edge).
- Load: READ in cycle 1; rspValid from cycle 2.
- Dword store: WRITE in cycle 1, committed at the edge ending cycle 1; rspValid from cycle 2.
- Sub-dword store: READ in cycle 1, WRITE in cycle 2; rspValid from cycle 3.
- Error: rspValid from cycle 1.
- rspReady high in the first RESP cycle → back in IDLE next cycle; back-to-back request accepted there.
- rspReady low: RESP held indefinitely, outputs unchanged.
- reqValid while not in IDLE: ignored (reqReady=0); request must be held by the datapath.
- Reset asserted, any state:
  - Immediately: state=IDLE, reqReady=0, rspValid=0, rspError=0, rspData=0, memRead=0, memWrite=0, memAddress=0, memWriteData=0.
  - A WRITE in progress whose edge has not occurred is not committed.
  - Memory contents are not touched.
- reqReady=1 from the first cycle after reset deasserts.

## Test plan
- Bench memory: word 0 = 0x8877665544332211; load dword addr 0 → rspValid in cycle 2, rspData=0x8877665544332211, rspError=0.
- Sub-dword loads, same memory:
  - Byte, addr 7, signed → 0xFFFFFFFFFFFFFF88.
  - Byte, addr 7, unsigned → 0x88.
  - Half, addr 2, signed → 0x4433.
  - Word, addr 4, signed → 0xFFFFFFFF88776655.
- Store byte 0xAB to addr 3 → READ then WRITE, memWriteData=0x88776655AB332211, rspValid in cycle 3; subsequent dword load returns that value.
- Errors:
  - Half load at addr 1 → rspError=1, rspData=0, memRead/memWrite never asserted.
  - Dword store at addr 40 (DEPTH=5) → rspError=1, no write.
- Hold rspReady=0 for 4 cycles → rspValid and rspData stable, reqReady=0, new reqValid ignored. Then rspReady=1 → IDLE; next request accepted the following cycle.
- Assert reset during WRITE before the edge → memWrite drops immediately, memory word unchanged, all outputs at reset values; normal load works after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store access stage: validates a request, then performs a single-word read, write,
// or read-modify-write against a combinational-read data memory and returns a held response.
module mem_access_unit #(
  parameter int DEPTH = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [63:0] reqAddr,
  input  logic [63:0] reqData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [63:0] rspData,
  output logic        rspError,
  output logic        memRead,
  output logic        memWrite,
  output logic [63:0] memAddress,
  output logic [63:0] memWriteData,
  input  logic [63:0] memReadData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [63:0] DEPTH_W = 64'(DEPTH);

  state_t      state, state_next;
  logic        is_write;
  logic [1:0]  size;
  logic        is_signed;
  logic [63:0] addr;
  logic [63:0] data;
  logic [63:0] merged;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic        misaligned;
  logic        out_of_range;
  logic        req_error;
  logic [63:0] word_index;

  // Bit offset of the addressed lane within the 64-bit word (little-endian).
  function automatic logic [5:0] lane_offset(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'b00:   return {a, 3'b000};
      2'b01:   return {a[2:1], 4'b0000};
      2'b10:   return {a[2], 5'b00000};
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [1:0] sz,
                                              input logic sgn, input logic [2:0] a);
    logic [63:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    lane = word >> lane_offset(sz, a);
    b = lane[7:0];
    h = lane[15:0];
    w = lane[31:0];
    case (sz)
      2'b00:   return sgn ? 64'(b) : {56'd0, lane[7:0]};
      2'b01:   return sgn ? 64'(h) : {48'd0, lane[15:0]};
      2'b10:   return sgn ? 64'(w) : {32'd0, lane[31:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] word, input logic [63:0] d,
                                              input logic [1:0] sz, input logic [2:0] a);
    logic [5:0]  sh;
    logic [63:0] m;
    sh = lane_offset(sz, a);
    m  = lane_mask(sz) << sh;
    return (word & ~m) | ((d << sh) & m);
  endfunction

  always_comb begin
    misaligned = ((reqSize == 2'b01) && reqAddr[0]) ||
                 ((reqSize == 2'b10) && (|reqAddr[1:0])) ||
                 ((reqSize == 2'b11) && (|reqAddr[2:0]));
    out_of_range = (reqAddr >> 3) >= DEPTH_W;
    req_error    = misaligned || out_of_range;
    word_index   = {3'b000, addr[63:3]};
  end

  always_comb begin
    state_next   = state;
    reqReady     = 1'b0;
    rspValid     = 1'b0;
    rspData      = 64'd0;
    rspError     = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = 64'd0;
    memWriteData = 64'd0;
    case (state)
      IDLE: begin
        reqReady = !reset;
        if (reqValid) begin
          if (req_error)                            state_next = RESP;
          else if (reqWrite && (reqSize == 2'b11))  state_next = WRITE;
          else                                      state_next = READ;
        end
      end
      READ: begin
        memRead    = 1'b1;
        memAddress = word_index;
        state_next = is_write ? WRITE : RESP;
      end
      WRITE: begin
        memWrite     = 1'b1;
        memAddress   = word_index;
        memWriteData = merged;
        state_next   = RESP;
      end
      RESP: begin
        rspValid = 1'b1;
        rspData  = rsp_data;
        rspError = rsp_error;
        if (rspReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control: state register, the only thing reset needs to clear since all outputs decode from it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: request latch, load extension and store merge.
  always_ff @(posedge clock) begin
    case (state)
      IDLE: begin
        if (reqValid && !reset) begin
          is_write  <= reqWrite;
          size      <= reqSize;
          is_signed <= reqSigned;
          addr      <= reqAddr;
          data      <= reqData;
          merged    <= reqData;
          rsp_error <= req_error;
          rsp_data  <= 64'd0;
        end
      end
      READ: begin
        if (is_write) merged   <= store_merge(memReadData, data, size, addr[2:0]);
        else          rsp_data <= load_extend(memReadData, size, is_signed, addr[2:0]);
      end
      default: ;
    endcase
  end

endmodule
